spi_mem_bridge: RTL
===================

Name: spi_mem_bridge

Overview:
- Sits directly downstream of the SPI memory slave, between its asynchronous SCK-domain memory bus (addr, data_out, rd, wr, data_in) and the system-clock memory arbiter.
- Synchronises the rd/wr strobes into clk, detects access events, latches address/data, and issues a req/ack transaction to the arbiter.
- Returns read data in a held register that drives the SPI slave's data_in.

Parameters:
- ADDR_WIDTH, 16, address width; matches SPI slave address bus.
- DATA_WIDTH, 8, data width; matches SPI slave data bus.
- SYNC_STAGES, 2, flops in each strobe synchroniser; legal range 2..4.
- TIMEOUT_CYCLES, 255, ack wait limit; used only with SPI_MEM_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- spi_addr  in  ADDR_WIDTH  address from SPI slave; asynchronous, quasi-static.
- spi_wdata  in  DATA_WIDTH  write data from SPI slave (its data_out).
- spi_rd  in  1  read strobe from SPI slave; asynchronous.
- spi_wr  in  1  write strobe from SPI slave; asynchronous.
- spi_rdata  out  DATA_WIDTH  held read data to SPI slave (its data_in).
- mem_req  out  1  access request to arbiter.
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_WIDTH  latched access address.
- mem_wdata  out  DATA_WIDTH  latched write data.
- mem_rdata  in  DATA_WIDTH  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion from arbiter.
- busy  out  1  high while a transaction is active or pending.
- overrun  out  1  sticky flag: an access event was dropped.
- timeout_err  out  1  sticky flag; present only with SPI_MEM_BRIDGE_TIMEOUT_EN.

Behaviour:
- Reset state: all outputs 0, spi_rdata 0, synchronisers 0, FSM IDLE, pending slot empty.
- Synchronisation: spi_rd and spi_wr each pass through SYNC_STAGES flops. A further flop holds the previous synced value for edge detection.
- Event timing:
  - Read event: rising edge of synced rd. rd rises at the start of a byte.
  - Write event: falling edge of synced wr. wr falls at the byte end, when spi_wdata holds the final byte and spi_addr has not yet incremented.
- Event capture: spi_addr and spi_wdata are sampled into the capture registers in the event cycle. The SPI buses are not synchronised; this is safe because they are stable for the whole SCK half-period around each event.
- Timing constraint:
  - SCK half-period must be at least SYNC_STAGES+2 clk cycles plus worst-case arbiter latency.
  - Read data must land in spi_rdata before the next SCK rising edge.
  - The bridge does not check this.
- Simultaneous read and write events in one cycle: write is serviced first; read goes to the pending slot.
- FSM states:
  - IDLE: on an event, load mem_addr/mem_wdata/mem_wr and assert mem_req the next cycle → REQ.
  - REQ: mem_req, mem_addr, mem_wr and mem_wdata are held stable until mem_ack.
    - On mem_ack with mem_wr=0: spi_rdata <= mem_rdata in the same edge.
    - On mem_ack, mem_req drops the next cycle.
    - If the pending slot is full → LOAD; otherwise → IDLE.
  - LOAD: move the pending slot into the mem_* registers; mem_req=1 the next cycle → REQ.
- Pending slot: one entry. An event arriving while in REQ/LOAD with the slot full is dropped and overrun <= 1. overrun clears only on reset.
- Ack outside REQ: ignored.
- busy = (state != IDLE) | pending valid.
- spi_rdata changes only on a read ack and is otherwise held.
- Reset mid-transaction: mem_req drops the cycle after reset is sampled; any in-flight ack is ignored.

Optional Feature:
- Macro: SPI_MEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (clog2 of TIMEOUT_CYCLES+1 bits) clears on entry to REQ and counts while in REQ without ack.
  - On reaching TIMEOUT_CYCLES: mem_req drops, timeout_err <= 1 (sticky until reset), spi_rdata <= all-ones for a read, FSM → IDLE (or LOAD if pending).
- Undefined: no counter, no timeout_err port; REQ waits for ack indefinitely.

Test Plan:
- Write path: spi_addr=0x1234, spi_wdata=0xA5, pulse spi_wr high 10 clk then low, ack after 3 cycles → one mem_req with mem_wr=1, addr 0x1234, data 0xA5; busy high until the cycle after ack.
- Read path: spi_addr=0x00FF, raise spi_rd, mem_rdata=0x3C with ack after 2 cycles → spi_rdata=0x3C the cycle after ack; mem_wr=0; no second request while rd stays high.
- Pending and overrun: hold ack off, fire three write events with addrs 1, 2, 3 → addrs 1 and 2 issued in order, 3 dropped, overrun=1 persists until reset.
- Simultaneous events: read and write edges detected in the same cycle → write request issued first, then read; both complete, overrun=0.
- Reset mid-REQ: assert reset while mem_req=1 → mem_req=0, busy=0, spi_rdata=0 the next cycle; a later ack is ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=16): read request, never ack → mem_req drops after 16 cycles, timeout_err=1, spi_rdata=0xFF.

Source files
------------

// File: rtl/spi_mem_bridge.sv
// Bridges the SPI slave's SCK-domain memory strobes into clk and runs one req/ack access per event.
// Optional ack timeout with sticky timeout_err: define SPI_MEM_BRIDGE_TIMEOUT_EN.
module spi_mem_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] spi_addr,
    input  logic [DATA_WIDTH-1:0] spi_wdata,
    input  logic                  spi_rd,
    input  logic                  spi_wr,
    output logic [DATA_WIDTH-1:0] spi_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  overrun
`ifdef SPI_MEM_BRIDGE_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_mem_bridge: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  rd_sync, wr_sync;
    logic                    rd_prev, wr_prev;
    logic                    rd_event, wr_event;
    logic                    pend_valid, pend_wr;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [DATA_WIDTH-1:0]   pend_wdata;
    logic                    start, load, req_end, push, push_wr, drop;
    logic                    timeout_hit;

    // Address/data buses are not synchronised: they are quasi-static around each strobe edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sync <= '0;
            wr_sync <= '0;
            rd_prev <= 1'b0;
            wr_prev <= 1'b0;
        end else begin
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], spi_rd};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], spi_wr};
            rd_prev <= rd_sync[SYNC_STAGES-1];
            wr_prev <= wr_sync[SYNC_STAGES-1];
        end
    end

    assign rd_event = rd_sync[SYNC_STAGES-1] & ~rd_prev;
    assign wr_event = ~wr_sync[SYNC_STAGES-1] & wr_prev;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Write wins a same-cycle collision; the single pending slot absorbs one extra event.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        load       = 1'b0;
        req_end    = 1'b0;
        push       = 1'b0;
        push_wr    = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (rd_event || wr_event) begin
                    start      = 1'b1;
                    state_next = REQ;
                    push       = rd_event & wr_event;
                end
            end
            REQ: begin
                req_end = mem_ack | timeout_hit;
                if (rd_event || wr_event) begin
                    if (pend_valid) begin
                        drop = 1'b1;
                    end else begin
                        push    = 1'b1;
                        push_wr = wr_event;
                        drop    = rd_event & wr_event;
                    end
                end
                if (req_end) state_next = (pend_valid || push) ? LOAD : IDLE;
            end
            LOAD: begin
                load       = 1'b1;
                state_next = REQ;
                drop       = rd_event | wr_event;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            spi_rdata  <= '0;
            pend_valid <= 1'b0;
            pend_wr    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            overrun    <= 1'b0;
        end else begin
            if (start) begin
                mem_req   <= 1'b1;
                mem_wr    <= wr_event;
                mem_addr  <= spi_addr;
                mem_wdata <= spi_wdata;
            end
            if (load) begin
                mem_req    <= 1'b1;
                mem_wr     <= pend_wr;
                mem_addr   <= pend_addr;
                mem_wdata  <= pend_wdata;
                pend_valid <= 1'b0;
            end
            if (req_end) begin
                mem_req <= 1'b0;
                if (!mem_wr) spi_rdata <= mem_ack ? mem_rdata : '1;
            end
            if (push) begin
                pend_valid <= 1'b1;
                pend_wr    <= push_wr;
                pend_addr  <= spi_addr;
                pend_wdata <= spi_wdata;
            end
            if (drop) overrun <= 1'b1;
        end
    end

    assign busy = (state != IDLE) | pend_valid;

`ifdef SPI_MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    logic [CNT_W-1:0] tmo_cnt;

    // Counter is zero on every entry to REQ because it clears in any other state.
    assign timeout_hit = (state == REQ) && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == REQ && !mem_ack) tmo_cnt <= tmo_cnt + 1'b1;
            else                          tmo_cnt <= '0;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
